vram_arbiter: RTL and testbench

- Shares one single-port pixel RAM between two requesters: display scanout prefetch (read-only) and host pixel writer/reader.
- Sits between the 800x600 VGA timing generator (1040-clock lines, 666 lines per frame, on the halved pixel clock) and frame memory.
- Display gets priority during active video. Arbitration is round-robin during blanking.
- A starvation counter guarantees host progress during long active stretches.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vram_arbiter_if.sv | 44 ++++
 rtl/vram_rd_tag_pipe.sv | 29 ++
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM types and constants.
// Used by the VRAM arbiter slice and the timing generator.
package vga_pkg;

  localparam int H_TOTAL  = 1040;
  localparam int H_ACTIVE = 800;
  localparam int V_TOTAL  = 666;
  localparam int V_ACTIVE = 600;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } own_t;

  typedef enum logic [1:0] {
    DISP_PRI   = 2'd0,
    RR         = 2'd1,
    FORCE_HOST = 2'd2
  } arb_st_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and RAM bundle of the VRAM arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr,
    input  host_req, host_we, host_addr, host_wdata,
    input  ram_rdata,
    output disp_gnt, disp_rvalid, disp_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_addr,
    output host_req, host_we, host_addr, host_wdata,
    output ram_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Owner tag shift pipe aligning read tags with RAM data.
// Async clear drops every in-flight read tag.
module vram_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  own_t i_own,
  output own_t o_own
);

  own_t r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_pipe[i] <= OWN_NONE;
    end else begin
      r_pipe[0] <= i_own;
      for (int i = 1; i < DEPTH; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_own = r_pipe[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: display priority in active video,
// round-robin in blanking, forced host slot on starvation.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RD_LAT        = 1,
  parameter int HOST_MAX_WAIT = 16
) (
  input logic           clk,
  input logic           rst_n,
  input logic           blank,
  vram_arbiter_if.slave bus
);

  localparam logic [7:0] MAXW = 8'(HOST_MAX_WAIT);

  arb_st_t           r_state, w_state_n;
  logic [7:0]        r_wait, w_wait_n;
  logic              r_ptr_host, w_ptr_n;
  logic              w_dgnt, w_hgnt;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  own_t              r_own, w_own_out;

  always_comb begin
    w_dgnt    = 1'b0;
    w_hgnt    = 1'b0;
    w_state_n = r_state;
    w_wait_n  = r_wait;
    unique case (r_state)
      DISP_PRI: begin
        w_dgnt = bus.disp_req;
        w_hgnt = bus.host_req & ~bus.disp_req;
        if (bus.host_req && !w_hgnt)
          w_wait_n = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
        else
          w_wait_n = '0;
        // blank rising outranks the starvation threshold
        if (blank) begin
          w_state_n = RR;
          w_wait_n  = '0;
        end else if (w_wait_n >= MAXW) begin
          w_state_n = FORCE_HOST;
        end
      end
      FORCE_HOST: begin
        w_hgnt    = bus.host_req;
        w_wait_n  = '0;
        w_state_n = blank ? RR : DISP_PRI;
      end
      RR: begin
        if (bus.disp_req && bus.host_req) begin
          w_hgnt = r_ptr_host;
          w_dgnt = ~r_ptr_host;
        end else begin
          w_dgnt = bus.disp_req;
          w_hgnt = bus.host_req;
        end
        w_wait_n  = '0;
        w_state_n = blank ? RR : DISP_PRI;
      end
      default: w_state_n = DISP_PRI;
    endcase
  end

  // pointer names the requester favoured at the next RR tie
  always_comb begin
    w_ptr_n = r_ptr_host;
    if (w_hgnt)      w_ptr_n = 1'b0;
    else if (w_dgnt) w_ptr_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DISP_PRI;
      r_wait     <= '0;
      r_ptr_host <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_wait     <= w_wait_n;
      r_ptr_host <= w_ptr_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_own       <= OWN_NONE;
    end else begin
      r_ram_en <= w_dgnt | w_hgnt;
      r_ram_we <= w_hgnt & bus.host_we;
      r_own    <= OWN_NONE;
      if (w_hgnt) begin
        r_ram_addr  <= bus.host_addr;
        r_ram_wdata <= bus.host_wdata;
        if (!bus.host_we) r_own <= OWN_HOST;
      end else if (w_dgnt) begin
        r_ram_addr <= bus.disp_addr;
        r_own      <= OWN_DISP;
      end
    end
  end

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .i_own (r_own),
    .o_own (w_own_out)
  );

  assign bus.disp_gnt    = w_dgnt;
  assign bus.host_gnt    = w_hgnt;
  assign bus.ram_en      = r_ram_en;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.disp_rvalid = (w_own_out == OWN_DISP);
  assign bus.host_rvalid = (w_own_out == OWN_HOST);
  assign bus.disp_rdata  = bus.disp_rvalid ? bus.ram_rdata : '0;
  assign bus.host_rdata  = bus.host_rvalid ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RD_LAT=1 and RD_LAT=2 instances.
module tb_vram_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic blank = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter_if bus1 ();
  vram_arbiter_if bus2 ();

  vram_arbiter #(
    .RD_LAT        (1),
    .HOST_MAX_WAIT (16)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .blank (blank),
    .bus   (bus1)
  );

  vram_arbiter #(
    .RD_LAT        (2),
    .HOST_MAX_WAIT (16)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .blank (blank),
    .bus   (bus2)
  );

  // latency-1 RAM for dut1
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] rd1 = 8'h00;
  always @(posedge clk) begin
    if (bus1.ram_en) begin
      if (bus1.ram_we) mem1[bus1.ram_addr[7:0]] <= bus1.ram_wdata;
      else             rd1 <= mem1[bus1.ram_addr[7:0]];
    end
  end
  assign bus1.ram_rdata = rd1;

  // latency-2 ROM for dut2
  logic [7:0] rd2a = 8'h00;
  logic [7:0] rd2b = 8'h00;
  always @(posedge clk) begin
    if (bus2.ram_en && !bus2.ram_we)
      rd2a <= (bus2.ram_addr == 19'h12345) ? 8'h3C : 8'h00;
    rd2b <= rd2a;
  end
  assign bus2.ram_rdata = rd2b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle1();
    bus1.disp_req = 1'b0;
    bus1.host_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus1.disp_req = 0; bus1.disp_addr = '0;
    bus1.host_req = 0; bus1.host_we = 0;
    bus1.host_addr = '0; bus1.host_wdata = '0;
    bus2.disp_req = 0; bus2.disp_addr = '0;
    bus2.host_req = 0; bus2.host_we = 0;
    bus2.host_addr = '0; bus2.host_wdata = '0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ram1", {bus1.ram_en, bus1.ram_we,
                     bus1.ram_addr, bus1.ram_wdata}, 0);
    chk("rst_rv1", {bus1.disp_rvalid, bus1.host_rvalid,
                    bus1.disp_rdata, bus1.host_rdata}, 0);
    chk("rst_ram2", {bus2.ram_en, bus2.ram_we,
                     bus2.ram_addr, bus2.ram_wdata}, 0);
    @(negedge clk); rst_n = 1'b1;

    // reset in the middle of a host read
    @(negedge clk);
    bus1.host_req = 1; bus1.host_we = 0; bus1.host_addr = 19'h10;
    #1 chk("mid_gnt", bus1.host_gnt, 1);
    @(negedge clk); bus1.host_req = 0;
    #1 chk("mid_en", bus1.ram_en, 1);
    rst_n = 1'b0;
    #1 chk("rst_async", bus1.ram_en, 0);
    @(negedge clk); #1;
    chk("rst_hold_rv", {bus1.host_rvalid, bus1.disp_rvalid}, 0);
    chk("rst_hold_ram", {bus1.ram_en, bus1.ram_we,
                         bus1.ram_addr, bus1.ram_wdata}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_rv", bus1.host_rvalid, 0);
    end

    // starvation: forced host write on the 17th waiting cycle
    @(negedge clk);
    bus1.disp_req = 1; bus1.disp_addr = 19'h100;
    bus1.host_req = 1; bus1.host_we = 1;
    bus1.host_addr = 19'h10; bus1.host_wdata = 8'hA5;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      chk("starve_h", bus1.host_gnt, 0);
      chk("starve_d", bus1.disp_gnt, 1);
    end
    @(negedge clk); #1;
    chk("force_h", bus1.host_gnt, 1);
    chk("force_d", bus1.disp_gnt, 0);
    @(negedge clk); bus1.host_req = 0; #1;
    chk("force_we", bus1.ram_we, 1);
    chk("force_en", bus1.ram_en, 1);
    chk("force_addr", bus1.ram_addr, 19'h10);
    chk("force_wd", bus1.ram_wdata, 8'hA5);
    chk("disp_resume", bus1.disp_gnt, 1);

    // blank rises; host write sets the pointer toward display
    @(negedge clk);
    bus1.disp_req = 0; blank = 1;
    bus1.host_req = 1; bus1.host_we = 1;
    bus1.host_addr = 19'h30; bus1.host_wdata = 8'h77;
    #1 chk("blank_edge_h", bus1.host_gnt, 1);

    // RR: D,H,D,H with a grant every cycle
    @(negedge clk);
    bus1.disp_req = 1; bus1.disp_addr = 19'h200;
    bus1.host_addr = 19'h20; bus1.host_wdata = 8'h11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("rr_d", bus1.disp_gnt, (k % 2 == 0));
      chk("rr_h", bus1.host_gnt, (k % 2 == 1));
    end

    // host read then display read, RD_LAT=1
    @(negedge clk); idle1(); blank = 0;
    @(negedge clk);
    bus1.host_req = 1; bus1.host_we = 0; bus1.host_addr = 19'h10;
    #1 chk("hrd_gnt", bus1.host_gnt, 1);
    @(negedge clk);
    bus1.host_req = 0;
    bus1.disp_req = 1; bus1.disp_addr = 19'h20;
    #1 chk("drd_gnt", bus1.disp_gnt, 1);
    chk("hrd_early", bus1.host_rvalid, 0);
    @(negedge clk); bus1.disp_req = 0; #1;
    chk("hrd_rv", bus1.host_rvalid, 1);
    chk("hrd_data", bus1.host_rdata, 8'hA5);
    chk("hrd_dx", bus1.disp_rvalid, 0);
    @(negedge clk); #1;
    chk("drd_rv", bus1.disp_rvalid, 1);
    chk("drd_data", bus1.disp_rdata, 8'h11);
    chk("drd_hx", bus1.host_rvalid, 0);
    @(negedge clk); #1;
    chk("rd_quiet", {bus1.disp_rvalid, bus1.host_rvalid}, 0);

    // RD_LAT=2 display read on dut2
    @(negedge clk);
    bus2.disp_req = 1; bus2.disp_addr = 19'h12345;
    #1 chk("l2_gnt", bus2.disp_gnt, 1);
    @(negedge clk); bus2.disp_req = 0; #1;
    chk("l2_addr", bus2.ram_addr, 19'h12345);
    chk("l2_rv1", bus2.disp_rvalid, 0);
    @(negedge clk); #1;
    chk("l2_rv2", bus2.disp_rvalid, 0);
    @(negedge clk); #1;
    chk("l2_rv3", bus2.disp_rvalid, 1);
    chk("l2_data", bus2.disp_rdata, 8'h3C);
    @(negedge clk); #1;
    chk("l2_rv4", bus2.disp_rvalid, 0);

    // blank rises during the forced host slot
    @(negedge clk);
    bus1.disp_req = 1; bus1.disp_addr = 19'h100;
    bus1.host_req = 1; bus1.host_we = 1;
    bus1.host_addr = 19'h50; bus1.host_wdata = 8'h66;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      #1 chk("t6_wait", bus1.host_gnt, 0);
    end
    @(negedge clk); blank = 1;
    #1 chk("t6_force", bus1.host_gnt, 1);
    @(negedge clk); #1;
    chk("t6_we", bus1.ram_we, 1);
    chk("t6_addr", bus1.ram_addr, 19'h50);
    chk("t6_rr_d", bus1.disp_gnt, 1);
    @(negedge clk); #1;
    chk("t6_rr_h", bus1.host_gnt, 1);
    chk("t6_rr_dx", bus1.disp_gnt, 0);
    @(negedge clk); idle1(); blank = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
